program_loader: RTL and testbench
=================================

# program_loader

Upstream feeder for the 32×16 unified memory of the multicycle processor. Accepts a framed byte stream (valid/ready), packs byte pairs into 16-bit words, and writes them to consecutive memory addresses using the memory's active-low write strobe. Holds the processor off while loading, and validates the frame with an XOR checksum. It replaces hard-wired program images as the way test programs enter memory.

## Interface
- `ADDR_W`, 5, memory address width.
- `DATA_W`, 16, memory word width (fixed at 2 bytes).
- `DEPTH`, 32, maximum words per frame.

- `clk`  in  1  system clock; all loader logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE, DONE, ERR.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_in`  out  DATA_W  memory write data.
- `mem_write`  out  1  active-low write strobe.
- `mem_read`  out  1  active-low read strobe.
- `proc_hold`  out  1  high while the processor must not access memory.
- `done`  out  1  level: last frame loaded and checksum matched.
- `err`  out  1  level: last frame rejected.

## Operation
- Frame format: `N` (word count, 1..DEPTH), then 2N data bytes with the high byte first, then `CK`. `CK` = XOR of `N` and all data bytes.
- A byte transfers on a rising edge where `byte_valid & byte_ready` is high.
- States and transitions:
  - **IDLE**: `start` → COUNT.
  - **COUNT**: accept `N`. If `N == 0` or `N > DEPTH` → ERR; otherwise → HI.
  - **HI**: accept the high byte → LO.
  - **LO**: accept the low byte → WRITE.
  - **WRITE**: one cycle with `mem_write = 0`, `mem_addr` = word index, `mem_in` = packed word. Increment the index. If the index reaches N → CHECK; otherwise → HI.
  - **CHECK**: accept `CK`. If it matches the running XOR → DONE; otherwise → ERR.
  - **DONE** and **ERR**: `start` → COUNT. Index and XOR clear on entry to COUNT.
- `byte_ready` = 1 only in COUNT, HI, LO, CHECK.
- `proc_hold` = 1 in COUNT, HI, LO, WRITE, CHECK, ERR. It is 0 in IDLE and DONE.
- `mem_read` stays 1 at all times; the loader never reads. When `proc_hold = 0`, the processor's memory mux owns the bus.
- `done`/`err` are set on entry to DONE/ERR and clear on entry to COUNT.
- A failed frame leaves memory partially written. Words are not rolled back.
- `start` is ignored while a load is in progress.

## Timing
- Reset values: state IDLE, `byte_ready` 0, `mem_addr` 0, `mem_in` 0, `mem_write` 1, `mem_read` 1, `proc_hold` 0, `done` 0, `err` 0, index 0, XOR 0.
- Reset mid-frame returns to IDLE next edge; partially loaded memory keeps its contents.
- `mem_addr`/`mem_in`/`mem_write` are registered and change only on rising edges. `mem_write` is low for exactly one full clock, so exactly one falling edge of the memory's negedge write falls inside the pulse with stable address and data.
- Minimum frame time with `byte_valid` held high: 1 + 3N + 1 cycles from COUNT entry to DONE entry.
- `byte_valid` low in an accepting state stalls the FSM indefinitely; no timeout.
- The last word (index DEPTH−1) is written at address 31, and the index wraps to 0 only via COUNT re-entry. Address never exceeds DEPTH−1.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t` (IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERR);
  - constants `LD_ADDR_W = 5`, `LD_DATA_W = 16`, `LD_DEPTH = 32`.
- One sub-module, `byte_packer`, is natural. It holds the high-byte register and the running XOR, and exposes the packed word and the checksum-match flag.
- Top level contains the FSM, word index, and memory-port registers.

## Test plan
- **Reset:** assert `rst` 2 cycles. All outputs take their reset values; `mem_write` stays 1 and `byte_ready` 0 after deassertion until `start`.
- **Two-word load:** `start`, then stream `02 80 03 02 E2 61`. Writes `mem[0] = 0x8003`, `mem[1] = 0x02E2`, each with one 1-cycle `mem_write = 0`. Then `done = 1`, `proc_hold = 0`, `err = 0`.
- **Bad checksum:** same frame with `CK = 0x60`. Both words are written, `err = 1`, `proc_hold = 1`, `done = 0`.
- **Invalid count:** `start`, then header `00` → ERR in the next cycle with no write. Header `21` (33) → ERR with no write.
- **Stalls and full depth:** N = 32 with random `byte_valid` gaps. All 32 addresses 0..31 are written in order, `done = 1`, and no write occurs while stalled.
- **Reset mid-frame:** assert `rst` after the 3rd data byte. Next cycle is IDLE with reset outputs; a subsequent full frame completes normally with `done = 1`.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader that fills the
// processor's unified memory from a framed byte stream.
package loader_pkg;

  localparam int LD_ADDR_W = 5;
  localparam int LD_DATA_W = 16;
  localparam int LD_DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } loader_state_t;

  // A word count is legal when it names between 1 and depth words.
  function automatic logic count_ok(input logic [7:0] n, input int depth);
    return (n != 8'd0) && (32'(n) <= 32'(depth));
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Byte-pair packer: remembers the high byte of the word being assembled and
// keeps the running XOR of every accepted frame byte except the checksum.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic        load_hi,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        ck_match
);

  logic [7:0] hi_q;
  logic [7:0] xor_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hi_q  <= 8'd0;
      xor_q <= 8'd0;
    end else begin
      if (take) begin
        xor_q <= xor_q ^ byte_in;
      end
      if (load_hi) begin
        hi_q <= byte_in;
      end
    end
  end

  // The low byte is taken straight from the stream on the cycle it transfers.
  assign word     = {hi_q, byte_in};
  assign ck_match = (byte_in == xor_q);

endmodule

// File: rtl/program_loader.sv
// Program loader: frame FSM, word index and registered memory-port drivers.
// Handshake: a byte transfers on a rising edge where byte_valid & byte_ready;
// byte_ready depends only on state, never on byte_valid.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DATA_W = LD_DATA_W,
  parameter int DEPTH  = LD_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  output logic              mem_read,
  output logic              proc_hold,
  output logic              done,
  output logic              err,
  output loader_state_t     dbg_state
);

  localparam int IDX_W = ADDR_W + 1;

  loader_state_t     state;
  loader_state_t     state_next;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  n_q;
  logic              xfer;
  logic              enter_count;
  logic              last_word;
  logic [15:0]       word;
  logic              ck_match;

  assign xfer        = byte_valid & byte_ready;
  assign enter_count = (state_next == COUNT) && (state != COUNT);
  assign last_word   = ((idx_q + IDX_W'(1)) == n_q);

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (enter_count),
    .take     (xfer && (state == COUNT || state == HI || state == LO)),
    .load_hi  (xfer && (state == HI)),
    .byte_in  (byte_in),
    .word     (word),
    .ck_match (ck_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = COUNT;
      COUNT: if (xfer) state_next = count_ok(byte_in, DEPTH) ? HI : ERR;
      HI:    if (xfer) state_next = LO;
      LO:    if (xfer) state_next = WRITE;
      WRITE: state_next = last_word ? CHECK : HI;
      CHECK: if (xfer) state_next = ck_match ? DONE : ERR;
      DONE:  if (start) state_next = COUNT;
      ERR:   if (start) state_next = COUNT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    proc_hold  = 1'b1;
    case (state)
      IDLE:  proc_hold  = 1'b0;
      DONE:  proc_hold  = 1'b0;
      COUNT: byte_ready = 1'b1;
      HI:    byte_ready = 1'b1;
      LO:    byte_ready = 1'b1;
      CHECK: byte_ready = 1'b1;
      default: byte_ready = 1'b0;
    endcase
  end

  // Address and data are loaded on the edge into WRITE and held afterwards,
  // so the strobe is low for exactly the one WRITE cycle with stable operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      n_q       <= '0;
      mem_addr  <= '0;
      mem_in    <= '0;
      mem_write <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_write <= (state_next != WRITE);
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);
      if (enter_count) begin
        idx_q <= '0;
        n_q   <= '0;
      end
      if (state == COUNT && xfer) begin
        n_q <= byte_in[IDX_W-1:0];
      end
      if (state == LO && xfer) begin
        mem_addr <= idx_q[ADDR_W-1:0];
        mem_in   <= DATA_W'(word);
      end
      if (state == WRITE) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign mem_read  = 1'b1;
  assign dbg_state = state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames, write scoreboard checked by a
// negedge monitor, status checks after each frame.
module tb_program_loader;
  import loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [4:0]    mem_addr;
  logic [15:0]   mem_in;
  logic          mem_write;
  logic          mem_read;
  logic          proc_hold;
  logic          done;
  logic          err;
  loader_state_t dbg_state;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [20:0] exp_q[$];
  logic [15:0] tb_mem [32];
  logic [15:0] frame_w [32];
  logic        prev_wr_low = 1'b0;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_in     (mem_in),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .proc_hold  (proc_hold),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write strobe must match the next expected {addr, data}
  always @(negedge clk) begin
    logic [20:0] exp;
    if (rst) begin
      prev_wr_low = 1'b0;
    end else begin
      if (mem_write == 1'b0) begin
        checks++;
        tb_mem[mem_addr] = mem_in;
        if (prev_wr_low) begin
          failures++;
          $display("FAIL wr_width: strobe low two cycles at addr=%0d", mem_addr);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", mem_addr, mem_in);
        end else begin
          exp = exp_q.pop_front();
          if ({mem_addr, mem_in} !== exp)
            begin
              failures++;
              $display("FAIL wr_data: got addr=%0d data=%h exp addr=%0d data=%h",
                       mem_addr, mem_in, exp[20:16], exp[15:0]);
            end
        end
      end
      prev_wr_low = (mem_write == 1'b0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  // Driver: present a byte after 'gap' idle cycles and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap, input logic push,
                           input logic [20:0] item);
    int n;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: byte=%h never accepted, state=%0d", b, dbg_state);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) exp_q.push_back(item);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int nw, input logic [7:0] ck, input int max_gap);
    send_byte(8'(nw), $urandom_range(0, max_gap), 1'b0, '0);
    for (int i = 0; i < nw; i++) begin
      send_byte(frame_w[i][15:8], $urandom_range(0, max_gap), 1'b0, '0);
      send_byte(frame_w[i][7:0], $urandom_range(0, max_gap), 1'b1, {5'(i), frame_w[i]});
    end
    send_byte(ck, $urandom_range(0, max_gap), 1'b0, '0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [7:0] frame_ck(input int nw);
    logic [7:0] x;
    x = 8'(nw);
    for (int i = 0; i < nw; i++) x = x ^ frame_w[i][15:8] ^ frame_w[i][7:0];
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_outputs", {byte_ready, mem_write, mem_read, proc_hold, done, err}, 6'b011000);
    chk("rst_addr_data", {mem_addr, mem_in}, 21'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {dbg_state, byte_ready, mem_write}, {IDLE, 1'b0, 1'b1});

    // Two-word load, byte_valid held high
    do_start();
    c0 = cyc;
    chk("start_count", {dbg_state, byte_ready, proc_hold}, {COUNT, 1'b1, 1'b1});
    frame_w[0] = 16'h8003;
    frame_w[1] = 16'h02E2;
    send_frame(2, 8'h61, 0);
    chk("two_word_status", {done, err, proc_hold, byte_ready}, 4'b1000);
    chk("two_word_state", dbg_state, DONE);
    chk("two_word_cycles", cyc - c0, 8);
    chk("two_word_mem", {tb_mem[0], tb_mem[1]}, 32'h8003_02E2);

    // Same frame with a wrong checksum
    do_start();
    chk("restart_clears_done", {done, err}, 2'b00);
    send_frame(2, 8'h60, 0);
    chk("bad_ck_status", {done, err, proc_hold, byte_ready}, 4'b0110);
    chk("bad_ck_state", dbg_state, ERR);

    // Invalid word counts
    do_start();
    chk("restart_clears_err", {done, err}, 2'b00);
    send_byte(8'h00, 0, 1'b0, '0);
    chk("count_zero_err", {dbg_state, err, done}, {ERR, 1'b1, 1'b0});
    do_start();
    send_byte(8'h21, 0, 1'b0, '0);
    chk("count_33_err", {dbg_state, err, done}, {ERR, 1'b1, 1'b0});

    // Full depth with random stalls
    for (int i = 0; i < 32; i++) frame_w[i] = {8'(i * 9 + 1), 8'(8'hF0 ^ i)};
    do_start();
    send_frame(32, frame_ck(32), 3);
    chk("full_status", {done, err, proc_hold}, 3'b100);
    chk("full_last_addr", mem_addr, 5'd31);
    chk("full_mem31", tb_mem[31], {8'(31 * 9 + 1), 8'(8'hF0 ^ 31)});

    // Reset after the third data byte
    frame_w[0] = 16'h8003;
    frame_w[1] = 16'h02E2;
    do_start();
    send_byte(8'h02, 0, 1'b0, '0);
    send_byte(8'h80, 0, 1'b0, '0);
    send_byte(8'h03, 0, 1'b1, {5'd0, 16'h8003});
    send_byte(8'h02, 0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", dbg_state, IDLE);
    chk("midrst_outputs", {byte_ready, mem_write, mem_read, proc_hold, done, err}, 6'b011000);
    chk("midrst_addr_data", {mem_addr, mem_in}, 21'd0);
    frame_w[0] = 16'h1234;
    frame_w[1] = 16'hABCD;
    do_start();
    send_frame(2, 8'h42, 1);
    chk("after_rst_status", {done, err, proc_hold}, 3'b100);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
